// File: rtl/segre_pkg.sv
// Shared SEGRE core types and constants used by the fetch stage.
package segre_pkg;

    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0)
    localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetch-queue slot: the fetched word and the address it came from
    typedef struct packed {
        logic [WORD_SIZE-1:0] instr;
        logic [ADDR_SIZE-1:0] pc;
    } if_fq_entry_t;

endpackage

// File: rtl/segre_fetch_queue.sv
// Fall-through FIFO between instruction memory and decode.
// The head slot is read combinationally, so a word written at one edge is
// visible on head right after that edge. Flush beats push and pop.
import segre_pkg::*;

module segre_fetch_queue #(
    parameter int  DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  if_fq_entry_t  push_data,
    input  logic          pop,
    output if_fq_entry_t  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    if_fq_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage array; contents are only meaningful while count covers the slot
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/segre_if_stage.sv
// SEGRE instruction-fetch stage.
// Issues word requests to instruction memory from the fetch PC, buffers the
// in-order responses in a small fall-through queue and hands them to decode.
// A credit rule (in-flight + buffered <= FQ_DEPTH) guarantees that every
// response finds a free slot. Redirects flush the queue and a drop counter
// discards responses still in flight from the old path.
// Optional build macro SEGRE_IF_PERF_CNT_EN adds fetch_cnt_o, a 32-bit count
// of instructions handed to decode.
//
// Handshake: a request transfers on a cycle with imem_req_o & imem_gnt_i;
// responses come back in request order, one per imem_rvalid_i pulse; decode
// takes the head when valid_if_o & !stall_if_i (and no redirect that cycle).
import segre_pkg::*;

module segre_if_stage #(
    parameter logic [ADDR_SIZE-1:0] BOOT_ADDR = 32'h0000_0000,
    parameter int                   FQ_DEPTH  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_req_o,
    output logic [ADDR_SIZE-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [WORD_SIZE-1:0] imem_rdata_i,
    output logic [WORD_SIZE-1:0] instr_o,
    output logic [ADDR_SIZE-1:0] pc_o,
    output logic                 valid_if_o,
    input  logic                 stall_if_i,
    input  logic                 redirect_i,
    input  logic [ADDR_SIZE-1:0] redirect_pc_i
`ifdef SEGRE_IF_PERF_CNT_EN
    ,
    output logic [31:0]          fetch_cnt_o
`endif
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [ADDR_SIZE-1:0] fpc;
    logic [ADDR_SIZE-1:0] rsp_pc;
    logic                 fetch_en;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        outstanding_nxt;
    logic [CW-1:0]        drop_cnt;
    logic [CW-1:0]        fq_count;
    logic [CW:0]          credit_used;
    logic                 deq;
    logic                 gnt_fire;
    logic                 rsp_keep;
    logic                 fq_pop;
    logic                 fq_empty;
    if_fq_entry_t         fq_head;
    if_fq_entry_t         fq_wdata;

    // A slot freed by decode this cycle is already available as a credit;
    // this keeps back-to-back fetch going with only two queue entries.
    assign deq         = !fq_empty && !stall_if_i;
    assign credit_used = {1'b0, outstanding} + {1'b0, fq_count} - (CW+1)'(deq);
    assign imem_req_o  = fetch_en && (credit_used < (CW+1)'(FQ_DEPTH));
    assign imem_addr_o = fpc;
    assign gnt_fire    = imem_req_o && imem_gnt_i;

    assign outstanding_nxt = outstanding + CW'(gnt_fire) - CW'(imem_rvalid_i);

    // A response is kept only when no stale responses remain and no redirect
    // is flushing the queue in the same cycle.
    assign rsp_keep = imem_rvalid_i && (drop_cnt == '0) && !redirect_i;
    assign fq_pop   = deq && !redirect_i;
    assign fq_wdata = '{instr: imem_rdata_i, pc: rsp_pc};

    segre_fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (redirect_i),
        .push      (rsp_keep),
        .push_data (fq_wdata),
        .pop       (fq_pop),
        .head      (fq_head),
        .empty     (fq_empty),
        .count     (fq_count)
    );

    // Fetch PC, response-address tracking, in-flight and drop counters.
    // rsp_pc is the address of the next response that will be kept: responses
    // are in order and sequential, and after a redirect every in-flight one is
    // dropped, so the next kept response belongs to the redirect target.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_en    <= 1'b0;
            fpc         <= BOOT_ADDR;
            rsp_pc      <= BOOT_ADDR;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            fetch_en    <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_i) begin
                fpc      <= redirect_pc_i;
                rsp_pc   <= redirect_pc_i;
                drop_cnt <= outstanding_nxt;
            end else begin
                if (gnt_fire)                         fpc      <= fpc + ADDR_SIZE'(4);
                if (imem_rvalid_i && drop_cnt != '0)  drop_cnt <= drop_cnt - CW'(1);
                if (rsp_keep)                         rsp_pc   <= rsp_pc + ADDR_SIZE'(4);
            end
        end
    end

    assign valid_if_o = !fq_empty;
    assign instr_o    = fq_empty ? NOP_INSTR : fq_head.instr;
    assign pc_o       = fq_empty ? rsp_pc    : fq_head.pc;

`ifdef SEGRE_IF_PERF_CNT_EN
    // Count instructions actually handed to decode; wraps at 2^32
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       fetch_cnt_o <= '0;
        else if (fq_pop) fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_segre_if_stage.sv
// Bench for segre_if_stage: randomized memory/decode/redirect traffic against
// an instruction-stream reference (sequential PCs, restarted at each redirect
// target or at BOOT_ADDR after reset) and a data function of the address.
import segre_pkg::*;

module tb_segre_if_stage;

    localparam logic [31:0] BOOT = 32'h0000_0000;
    localparam int          FQD  = 2;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid_if;
    logic        stall_if;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef SEGRE_IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    segre_if_stage #(
        .BOOT_ADDR (BOOT),
        .FQ_DEPTH  (FQD)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_o       (instr),
        .pc_o          (pc),
        .valid_if_o    (valid_if),
        .stall_if_i    (stall_if),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc)
`ifdef SEGRE_IF_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];
    logic [31:0] exp_pc;
    int          perf_exp;
    int          consumed;
    int          idle;
    int          redir_rv_seen;
    logic        prev_req, prev_gnt, prev_redirect, prev_hold;
    logic [31:0] prev_addr, prev_pc, prev_instr;
    logic        last_valid;

    // knobs
    int   p_gnt, p_rv, p_stall, p_redir;
    logic force_stall, force_nogrant, force_redir, redir_on_rv;
    logic [31:0] force_target;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        req_addr_q.delete();
        req_cyc_q.delete();
        exp_pc        = BOOT;
        perf_exp      = 0;
        idle          = 0;
        prev_req      = 1'b0;
        prev_gnt      = 1'b0;
        prev_redirect = 1'b0;
        prev_hold     = 1'b0;
        prev_addr     = '0;
        prev_pc       = '0;
        prev_instr    = '0;
        last_valid    = 1'b0;
    endtask

    // Assert reset from the current time, check reset values at once,
    // then release between edges and check no request before the next edge.
    task automatic do_reset();
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        stall_if    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        #1;
        check("rst_req",   imem_req, 0);
        check("rst_valid", valid_if, 0);
        check("rst_instr", instr,    NOP_INSTR);
        check("rst_pc",    pc,       BOOT);
`ifdef SEGRE_IF_PERF_CNT_EN
        check("rst_fetch_cnt", fetch_cnt, 0);
`endif
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("req_after_release", imem_req, 0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One clock cycle: drive inputs, sample outputs, check, update the model.
    task automatic step();
        logic rv;
        rv = (req_addr_q.size() > 0) && (req_cyc_q[0] < cyc) &&
             ($urandom_range(99) < p_rv);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(req_addr_q[0]) : $urandom;
        stall_if    = force_stall ? 1'b1 : ($urandom_range(99) < p_stall);
        imem_gnt    = force_nogrant ? 1'b0 : ($urandom_range(99) < p_gnt);
        redirect    = force_redir || (redir_on_rv && rv) || ($urandom_range(99) < p_redir);
        redirect_pc = force_redir ? force_target : (32'h100 + ($urandom_range(0, 63) << 2));
        #1;

        if (prev_redirect) check("valid_after_redirect", valid_if, 0);
        if (prev_req && !prev_gnt && !prev_redirect) check("addr_hold", imem_addr, prev_addr);
        if (prev_hold) begin
            check("stall_valid", valid_if, 1);
            check("stall_pc",    pc,       prev_pc);
            check("stall_instr", instr,    prev_instr);
        end
        check("credit_bound", (req_addr_q.size() <= FQD), 1);

        if (valid_if && !stall_if && !redirect) begin
            check("pc_stream",    pc,    exp_pc);
            check("instr_stream", instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            perf_exp++;
            consumed++;
            idle = 0;
        end else if (!stall_if) begin
            idle++;
            if (idle > 300) begin
                check("progress_timeout", 0, 1);
                idle = 0;
            end
        end

        if (redirect && rv) redir_rv_seen++;
        if (imem_req && imem_gnt) begin
            req_addr_q.push_back(imem_addr);
            req_cyc_q.push_back(cyc);
        end
        if (rv) begin
            void'(req_addr_q.pop_front());
            void'(req_cyc_q.pop_front());
        end
        if (redirect) exp_pc = redirect_pc;

        prev_req      = imem_req;
        prev_gnt      = imem_gnt;
        prev_addr     = imem_addr;
        prev_redirect = redirect;
        prev_hold     = valid_if && stall_if && !redirect;
        prev_pc       = pc;
        prev_instr    = instr;
        last_valid    = valid_if;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_knobs(input int g, input int r, input int s, input int d);
        p_gnt = g; p_rv = r; p_stall = s; p_redir = d;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        rst = 1'b1;
        force_stall = 0; force_nogrant = 0; force_redir = 0; redir_on_rv = 0;
        force_target = 32'h100;
        consumed = 0; redir_rv_seen = 0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Full-rate streaming: once valid appears it must stay up every cycle
        set_knobs(100, 100, 0, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (seen) check("stream_gap", last_valid, 1);
            if (last_valid) seen = 1;
        end
        check("stream_throughput", (consumed >= 6), 1);

        // Grant withheld for three cycles: address held, nothing counted
        force_nogrant = 1;
        for (int i = 0; i < 3; i++) step();
        force_nogrant = 0;
        for (int i = 0; i < 6; i++) step();

        // Decode stalled five cycles: head frozen, credit bound holds
        force_stall = 1;
        for (int i = 0; i < 5; i++) step();
        check("queue_occupied_pre_reset", valid_if, 1);

        // Reset in the middle of a full queue, then restart at BOOT_ADDR
        force_stall = 0;
        do_reset();
        consumed = 0;
        for (int i = 0; i < 8; i++) step();
        check("restart_progress", (consumed >= 3), 1);

        // Build up two in-flight requests, then redirect to 0x100
        set_knobs(100, 0, 0, 0);
        for (int i = 0; i < 10 && req_addr_q.size() < 2; i++) step();
        check("redirect_setup_outstanding", req_addr_q.size(), 2);
        set_knobs(0, 100, 0, 0);
        force_redir = 1; force_target = 32'h100;
        step();
        force_redir = 0;
        set_knobs(100, 100, 0, 0);
        consumed = 0;
        for (int i = 0; i < 10; i++) step();
        check("redirect_progress", (consumed >= 3), 1);

        // Redirect coinciding with a response
        redir_on_rv = 1;
        for (int i = 0; i < 20 && redir_rv_seen == 0; i++) step();
        redir_on_rv = 0;
        check("redirect_with_rvalid_seen", (redir_rv_seen > 0), 1);
        for (int i = 0; i < 6; i++) step();

        // Long randomized run
        set_knobs(70, 60, 30, 4);
        for (int i = 0; i < 3000; i++) step();
        set_knobs(100, 100, 0, 0);
        for (int i = 0; i < 10; i++) step();

`ifdef SEGRE_IF_PERF_CNT_EN
        check("fetch_cnt_final", fetch_cnt, perf_exp);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/segre_if_stage.md
SEGRE_IF_STAGE -- requirements
Module: segre_if_stage

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 2, fetch-queue entries (power of two, >=2).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports imem_req_o/imem_addr_o, output, 1/ADDR_SIZE, instruction-memory request and word address.
REQ-006 SHALL have ports imem_gnt_i/imem_rvalid_i/imem_rdata_i, input, 1/1/WORD_SIZE, grant, in-order response valid, response data.
REQ-007 SHALL have ports instr_o/pc_o/valid_if_o, output, WORD_SIZE/ADDR_SIZE/1, instruction, PC and valid toward the decode stage.
REQ-008 SHALL have port stall_if_i, input, 1, decode stage not consuming this cycle.
REQ-009 SHALL have ports redirect_i/redirect_pc_i, input, 1/ADDR_SIZE, taken branch/jump and its target.

Function
REQ-010 SHALL keep fetch PC register fpc; request issued when imem_req_o & imem_gnt_i, after which fpc <= fpc + 4.
REQ-011 SHALL assert imem_req_o only while outstanding + queue_count < FQ_DEPTH (credit rule), so a response never meets a full queue.
REQ-012 SHALL hold imem_addr_o = fpc stable while imem_req_o high and not granted, except when redirect_i changes it.
REQ-013 SHALL count outstanding requests: +1 on grant, -1 on imem_rvalid_i, both same cycle -> unchanged; max FQ_DEPTH.
REQ-014 SHALL push {imem_rdata_i, address of that request} into queue on imem_rvalid_i when drop counter is 0.
REQ-015 SHALL drive instr_o/pc_o from queue head and valid_if_o = queue not empty; empty -> instr_o = NOP_INSTR, valid_if_o = 0.
REQ-016 SHALL pop head when valid_if_o & !stall_if_i; outputs unchanged while stall_if_i high.
REQ-017 On redirect_i SHALL, same edge: clear queue, set fpc <= redirect_pc_i, load drop counter with outstanding in-flight requests (including one granted this cycle, excluding one answered this cycle).
REQ-018 SHALL discard responses while drop counter > 0, decrementing it per discarded response.
REQ-019 SHALL, on redirect_i together with imem_rvalid_i, discard that response; redirect beats pop and push.
REQ-020 SHALL present valid_if_o = 0 the cycle after a redirect; first redirected instruction visible no earlier than 2 cycles after redirect_i.
REQ-021 SHALL be fall-through: response arriving at cycle N to an empty queue is on instr_o with valid_if_o at cycle N+1.

Reset
REQ-022 SHALL, on rst_i high, asynchronously: fpc = BOOT_ADDR, queue empty, outstanding = 0, drop = 0, imem_req_o = 0, valid_if_o = 0, instr_o = NOP_INSTR, pc_o = BOOT_ADDR.
REQ-023 SHALL ignore responses to requests issued before a reset; memory side is reset together with this block.
REQ-024 SHALL raise imem_req_o no earlier than first rising edge after rst_i deasserts.

Configuration
REQ-025 SHALL support macro SEGRE_IF_PERF_CNT_EN: when defined, adds output fetch_cnt_o (32 bits) counting pops to decode, wrapping at 2^32, reset 0; when undefined, port and counter absent.

Structure
REQ-026 SHALL take WORD_SIZE, ADDR_SIZE, NOP_INSTR from segre_pkg and add there typedef if_fq_entry_t {instr, pc}.
REQ-027 SHALL implement queue as sub-module segre_fetch_queue (FIFO, push/pop/flush, count output).

Verification
REQ-028 Reset release, gnt=1, rvalid one cycle after grant, stall 0 -> addresses 0x0,0x4,0x8 issued; pc_o 0x0,0x4,0x8 on consecutive cycles, valid 1.
REQ-029 stall_if_i held 5 cycles with FQ_DEPTH=2 -> at most 2 requests beyond head; instr_o/pc_o constant; no push lost.
REQ-030 redirect_i to 0x100 with 2 outstanding -> next 2 responses dropped; first valid pc_o = 0x100.
REQ-031 redirect_i same cycle as imem_rvalid_i -> response discarded, valid_if_o 0 next cycle.
REQ-032 imem_gnt_i low 3 cycles -> imem_addr_o constant, single request counted.
REQ-033 rst_i asserted mid-stream with queue full -> outputs immediately at reset values; restart fetch at BOOT_ADDR; with SEGRE_IF_PERF_CNT_EN, fetch_cnt_o = 0.
